// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle for pc_next_unit: control-flow inputs, trap request and the PC offer.
// slave is the PC unit's view; master is the driver's (pipeline/bench) view.
interface pc_next_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             fetch_ready_i;
    logic             stall_i;
    logic             br_taken_i;
    logic             jalr_i;
    logic [XLEN-1:0]  br_pc_i;
    logic [XLEN-1:0]  br_imm_i;
    logic [XLEN-1:0]  rs1_i;
    logic             trap_i;
    logic [XLEN-1:0]  trap_vec_i;
    logic [XLEN-1:0]  pc_o;
    logic             pc_valid_o;
    logic             redirect_o;
    logic [XLEN-1:0]  link_o;
    logic             misalign_o;
    logic [XLEN-1:0]  misalign_addr_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        output fetch_ready_i, stall_i, br_taken_i, jalr_i, br_pc_i, br_imm_i,
               rs1_i, trap_i, trap_vec_i,
        input  pc_o, pc_valid_o, redirect_o, link_o, misalign_o,
               misalign_addr_o, redirect_cnt_o
    );

    modport slave (
        input  fetch_ready_i, stall_i, br_taken_i, jalr_i, br_pc_i, br_imm_i,
               rs1_i, trap_i, trap_vec_i,
        output pc_o, pc_valid_o, redirect_o, link_o, misalign_o,
               misalign_addr_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_next_unit.sv
// Registered fetch PC: trap > aligned redirect > misaligned report > sequential advance,
// offered to fetch via valid/ready, with misalignment capture and a saturating redirect count.
module pc_next_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      IALIGN       = 4,
    parameter int unsigned      CNT_W        = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    pc_next_unit_if.slave bus
);
    localparam int unsigned AB   = (IALIGN == 2) ? 1 : 2;
    localparam logic [0:0]  BOOT = 1'b0;
    localparam logic [0:0]  RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [XLEN-1:0]  r_pc;
    logic             r_redirect;
    logic             r_misalign;
    logic [XLEN-1:0]  r_misalign_addr;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]  w_base;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_trap_pc;
    logic             w_misaligned;
    logic             w_take_branch;
    logic             w_redirect;
    logic             w_advance;

    always_comb begin
        w_base   = bus.jalr_i ? bus.rs1_i : bus.br_pc_i;
        w_target = w_base + bus.br_imm_i;
        // JALR clears bit 0 before alignment is judged, so odd rs1 alone never faults.
        if (bus.jalr_i) begin
            w_target[0] = 1'b0;
        end
        w_misaligned  = bus.br_taken_i && (w_target[AB-1:0] != '0);
        w_take_branch = bus.br_taken_i && !w_misaligned;
        w_trap_pc     = bus.trap_i ? {bus.trap_vec_i[XLEN-1:AB], {AB{1'b0}}} : '0;
        w_redirect    = bus.trap_i || w_take_branch;
        w_advance     = (r_state == RUN) && bus.fetch_ready_i && !bus.stall_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= BOOT;
            r_pc            <= RESET_VECTOR;
            r_redirect      <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
            r_cnt           <= '0;
        end else begin
            r_state    <= RUN;
            r_redirect <= w_redirect;
            r_misalign <= 1'b0;
            if (bus.trap_i) begin
                r_pc <= w_trap_pc;
            end else if (w_take_branch) begin
                r_pc <= w_target;
            end else if (bus.br_taken_i) begin
                r_misalign      <= 1'b1;
                r_misalign_addr <= w_target;
            end else if (w_advance) begin
                r_pc <= r_pc + XLEN'(IALIGN);
            end
            if (w_redirect && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_o            = r_pc;
    assign bus.pc_valid_o      = (r_state == RUN);
    assign bus.redirect_o      = r_redirect;
    assign bus.link_o          = bus.br_pc_i + XLEN'(4);
    assign bus.misalign_o      = r_misalign;
    assign bus.misalign_addr_o = r_misalign_addr;
    assign bus.redirect_cnt_o  = r_cnt;
endmodule
